// File: rtl/eth_clk_speed_detect.sv
// rtl/eth_clk_speed_detect.sv - measures a slow MII/RGMII clock and publishes a debounced 10M/100M speed mode
module eth_clk_speed_detect #(
  parameter int CNT_W      = 8,
  parameter int P100_MIN   = 4,
  parameter int P100_MAX   = 6,
  parameter int P10_MIN    = 40,
  parameter int P10_MAX    = 60,
  parameter int TIMEOUT    = 255,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             sig_in,
  output logic [1:0]       speed_mode,
  output logic             speed_valid,
  output logic [CNT_W-1:0] period,
  output logic             meas_stb,
  output logic             change_stb
);

  localparam int ST_W = $clog2(STABLE_CNT + 1);
  localparam logic [1:0]       MODE_NONE  = 2'b00;
  localparam logic [1:0]       MODE_10M   = 2'b01;
  localparam logic [1:0]       MODE_100M  = 2'b10;
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_P100_MIN = CNT_W'(P100_MIN);
  localparam logic [CNT_W-1:0] L_P100_MAX = CNT_W'(P100_MAX);
  localparam logic [CNT_W-1:0] L_P10_MIN  = CNT_W'(P10_MIN);
  localparam logic [CNT_W-1:0] L_P10_MAX  = CNT_W'(P10_MAX);
  localparam logic [ST_W-1:0]  L_STABLE   = ST_W'(STABLE_CNT);

  logic             r_sync1, r_sync2, r_hist;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [1:0]       r_cand;
  logic [ST_W-1:0]  r_stable;
  logic [1:0]       r_mode;
  logic             r_valid;
  logic [CNT_W-1:0] r_period;
  logic             r_meas_stb, r_change_stb;

  logic             w_edge;
  logic [1:0]       w_class;
  logic [1:0]       w_next_cand;
  logic [ST_W-1:0]  w_next_stable;

  assign w_edge = r_sync2 & ~r_hist;

  // Synchronizer and edge history run even while measurement is disabled.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Class 00 doubles as "invalid" since a valid class is never 00.
  always_comb begin
    w_class       = MODE_NONE;
    w_next_cand   = MODE_NONE;
    w_next_stable = '0;
    if (r_cnt >= L_P100_MIN && r_cnt <= L_P100_MAX) begin
      w_class = MODE_100M;
    end else if (r_cnt >= L_P10_MIN && r_cnt <= L_P10_MAX) begin
      w_class = MODE_10M;
    end
    if (w_class == MODE_NONE) begin
      w_next_cand   = MODE_NONE;
      w_next_stable = '0;
    end else if (w_class == r_cand) begin
      w_next_cand   = r_cand;
      w_next_stable = (r_stable == L_STABLE) ? r_stable : r_stable + 1'b1;
    end else begin
      w_next_cand   = w_class;
      w_next_stable = ST_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_cand       <= MODE_NONE;
      r_stable     <= '0;
      r_mode       <= MODE_NONE;
      r_valid      <= 1'b0;
      r_period     <= '0;
      r_meas_stb   <= 1'b0;
      r_change_stb <= 1'b0;
    end else begin
      r_meas_stb   <= 1'b0;
      r_change_stb <= 1'b0;
      if (clk_en) begin
        if (w_edge) begin
          r_cnt   <= L_ONE;
          r_armed <= 1'b1;
          if (r_armed) begin
            r_period   <= r_cnt;
            r_meas_stb <= 1'b1;
            r_cand     <= w_next_cand;
            r_stable   <= w_next_stable;
            if (w_next_stable == L_STABLE && w_next_cand != r_mode) begin
              r_mode       <= w_next_cand;
              r_valid      <= (w_next_cand != MODE_NONE);
              r_change_stb <= 1'b1;
            end
          end
        end else if (r_armed) begin
          if (r_cnt == L_TIMEOUT) begin
            // Clock lost: drop the mode at once, no debounce.
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_cand   <= MODE_NONE;
            r_stable <= '0;
            r_mode   <= MODE_NONE;
            r_valid  <= 1'b0;
            if (r_mode != MODE_NONE) r_change_stb <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign speed_mode  = r_mode;
  assign speed_valid = r_valid;
  assign period      = r_period;
  assign meas_stb    = r_meas_stb;
  assign change_stb  = r_change_stb;

endmodule
